instr_fetch: RTL and testbench

Instruction fetch unit for the RV32I core and the initiator side of the instruction-memory port. It holds the program counter and drives the fetch address to the instruction memory, which returns a 32-bit word combinationally in the same cycle. Each fetched {pc, instr} pair is captured into a 2-entry fetch buffer and handed to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the buffer and restart fetch.

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_buf.sv | 59 +++++
 rtl/instr_fetch.sv | 60 ++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared RV32I fetch definitions: word widths, reset PC, PC step and buffer entry layout.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned ENTRY_W = XLEN + ILEN;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// Two-entry {pc, instr} FIFO between the fetch stage and decode, with synchronous flush.
module instr_fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ENTRY_W-1:0] i_din,
    output logic [ENTRY_W-1:0] o_dout,
    output logic [1:0]         o_count
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign w_full = (r_count == 2'd2);
    assign w_pop  = i_pop && (r_count != 2'd0);
    // A write into a full buffer is only legal when the head leaves in the same cycle.
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= fetch_entry_t'(i_din);
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC register, imem request, redirect mux and decode-side buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    logic [XLEN-1:0]    r_pc;
    logic [1:0]         w_count;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;
    fetch_entry_t       w_head;

    assign w_pop  = dec_valid && dec_ready;
    // Redirect suppresses the push: the word at the old PC is on the wrong path.
    assign w_push = !redirect_valid && ((w_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign w_din = {r_pc, imem_instr};

    instr_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    assign w_head    = fetch_entry_t'(w_dout);
    assign imem_addr = r_pc;
    assign dec_valid = (w_count != 2'd0);
    assign dec_instr = w_head.instr;
    assign dec_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch against a small combinational imem model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    // Three program words at 0/4/8; every other address returns its own inverse.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0020E4B3;
            32'h4:   return 32'h401001B3;
            32'h8:   return 32'h00C3A0B3;
            default: return ~a;
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, 32'h0); end
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        n_tests++; if (dec_instr !== 32'h0) begin n_fail++;
            $display("FAIL reset_dec_instr: got %h expected %h", dec_instr, 32'h0); end
        n_tests++; if (dec_pc !== 32'h0) begin n_fail++;
            $display("FAIL reset_dec_pc: got %h expected %h", dec_pc, 32'h0); end
    endtask

    task automatic test_sequential();
        dec_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (dec_valid !== 1'b1) begin n_fail++;
                $display("FAIL seq_valid[%0d]: got %b expected 1", i, dec_valid); end
            n_tests++; if (dec_pc !== 32'(4 * i)) begin n_fail++;
                $display("FAIL seq_pc[%0d]: got %h expected %h", i, dec_pc, 32'(4 * i)); end
            n_tests++; if (dec_instr !== mem_word(32'(4 * i))) begin n_fail++;
                $display("FAIL seq_instr[%0d]: got %h expected %h", i, dec_instr,
                         mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (5) @(negedge clk);
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++;
            $display("FAIL bp_imem_addr: got %h expected %h", imem_addr, 32'h8); end
        n_tests++; if (dut.w_count !== 2'd2) begin n_fail++;
            $display("FAIL bp_count: got %0d expected 2", dut.w_count); end
        dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * k)) begin n_fail++;
                $display("FAIL bp_order[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                         k, dec_valid, dec_pc, 32'(4 * k)); end
            n_tests++; if (dec_instr !== mem_word(32'(4 * k))) begin n_fail++;
                $display("FAIL bp_instr[%0d]: got %h expected %h", k, dec_instr,
                         mem_word(32'(4 * k))); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL redir_flush_valid: got %b expected 0", dec_valid); end
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++;
            $display("FAIL redir_imem_addr: got %h expected %h", imem_addr, 32'h100); end
        @(negedge clk);
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin n_fail++;
            $display("FAIL redir_target: got valid=%b pc=%h expected valid=1 pc=%h",
                     dec_valid, dec_pc, 32'h100); end
        n_tests++; if (dec_instr !== 32'hFFFF_FEFF) begin n_fail++;
            $display("FAIL redir_instr: got %h expected %h", dec_instr, 32'hFFFF_FEFF); end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (dut.w_count !== 2'd2 || dec_pc !== 32'h0) begin n_fail++;
            $display("FAIL rpop_full: got count=%0d pc=%h expected count=2 pc=%h",
                     dut.w_count, dec_pc, 32'h0); end
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++; if (dec_valid !== 1'b0 || dut.w_count !== 2'd0) begin n_fail++;
            $display("FAIL rpop_flush: got valid=%b count=%0d expected valid=0 count=0",
                     dec_valid, dut.w_count); end
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++;
            $display("FAIL rpop_imem_addr: got %h expected %h", imem_addr, 32'h200); end
        @(negedge clk);
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin n_fail++;
            $display("FAIL rpop_next: got valid=%b pc=%h expected valid=1 pc=%h",
                     dec_valid, dec_pc, 32'h200); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL wrap_imem_addr: got %h expected %h", imem_addr, 32'hFFFF_FFFC); end
        @(negedge clk);
        n_tests++; if (dec_pc !== 32'hFFFF_FFFC || dec_instr !== 32'h3) begin n_fail++;
            $display("FAIL wrap_last: got pc=%h instr=%h expected pc=%h instr=%h",
                     dec_pc, dec_instr, 32'hFFFF_FFFC, 32'h3); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL wrap_pc: got %h expected %h", imem_addr, 32'h0); end
        @(negedge clk);
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0020E4B3)
            begin n_fail++;
            $display("FAIL wrap_zero: got valid=%b pc=%h instr=%h expected 1 %h %h",
                     dec_valid, dec_pc, dec_instr, 32'h0, 32'h0020E4B3); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (dut.w_count !== 2'd2) begin n_fail++;
            $display("FAIL areset_prefill: got %0d expected 2", dut.w_count); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++;
            $display("FAIL areset_valid: got %b expected 0", dec_valid); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL areset_imem_addr: got %h expected %h", imem_addr, 32'h0); end
        n_tests++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin n_fail++;
            $display("FAIL areset_storage: got pc=%h instr=%h expected 0 0", dec_pc, dec_instr); end
        @(negedge clk);
        rst = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * i)) begin n_fail++;
                $display("FAIL areset_restart[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                         i, dec_valid, dec_pc, 32'(4 * i)); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
